sar_afe_model: RTL and testbench
================================

SAR_AFE_MODEL -- requirements
Module: sar_afe_model

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately regardless of clk.
REQ-003 En  input  1  conversion enable, shared with the SAR algorithm block.
REQ-004 vin_data  input  8  unsigned analog-input code to be converted.
REQ-005 vin_valid  input  1  vin_data offered this cycle.
REQ-006 vin_ready  output  1  block can accept a new sample; high only in IDLE.
REQ-007 B  input  8  DAC trial code from SAR logic, MSB first.
REQ-008 BN  input  8  complementary DAC code from SAR logic; expected BN = ~B.
REQ-009 Op  output  1  comparator positive decision, registered.
REQ-010 Om  output  1  comparator negative decision, registered.
REQ-011 cmp_valid  output  1  Op/Om hold a decision from the previous cycle's B.
REQ-012 trial_cnt  output  4  comparisons completed in the current conversion, 0..8.
REQ-013 err  output  1  sticky flag: B/BN not complementary during CONVERT.

Function
REQ-014 FSM states SHALL be IDLE, SAMPLE, CONVERT, DONE; encoding is free.
REQ-015 IDLE: vin_ready=1, Op=Om=0, cmp_valid=0; vin_valid=1 in the same cycle SHALL capture vin_data into hold register vin_q and move to SAMPLE.
REQ-016 vin_valid outside IDLE SHALL be ignored and vin_q SHALL remain unchanged.
REQ-017 SAMPLE: wait with Op=Om=0; En=1 moves to CONVERT on the next edge; trial_cnt cleared to 0.
REQ-018 CONVERT, each cycle: Op<=1, Om<=0 if vin_q >= B (unsigned), else Op<=0, Om<=1; cmp_valid<=1; trial_cnt increments.
REQ-019 Comparison latency SHALL be exactly one cycle: B sampled at edge N appears on Op/Om after edge N.
REQ-020 Op and Om SHALL never both be 1; both 0 means no decision.
REQ-021 Equality (vin_q == B) SHALL resolve as Op=1.
REQ-022 The 8th comparison (trial_cnt reaching 8) SHALL move to DONE; trial_cnt SHALL saturate at 8 and hold that value in DONE.
REQ-023 DONE: Op=Om=0, cmp_valid=0 for exactly one cycle, then IDLE; trial_cnt cleared on entering IDLE.
REQ-024 En=0 in CONVERT SHALL abort: next state IDLE, Op=Om=0, cmp_valid=0, trial_cnt=0; comparison in that cycle discarded.
REQ-025 En=0 in SAMPLE SHALL keep SAMPLE (hold vin_q).
REQ-026 In CONVERT, BN != ~B SHALL set err=1; err holds until the next SAMPLE entry, which clears it; comparison still uses B only.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, vin_q=0x00, Op=0, Om=0, cmp_valid=0, trial_cnt=0, err=0.
REQ-028 vin_ready SHALL be 0 while rst=0 and 1 from the first clk edge after rst returns to 1.
REQ-029 Reset asserted mid-CONVERT SHALL discard the conversion; no decision is produced after release until a new sample completes SAMPLE->CONVERT.

Verification
REQ-030 vin_data=0xA5 accepted, En=1, B=0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 (BN=~B) -> Op sequence 1,0,1,0,0,1,0,1 each one cycle later; trial_cnt 1..8; DONE then IDLE, err=0.
REQ-031 vin_data=0x00, B=0x00 -> Op=1 (equality); B=0x01 -> Om=1; vin_data=0xFF, B=0xFF -> Op=1.
REQ-032 In CONVERT, B=0x80, BN=0x80 -> err=1 next cycle, remains 1 through DONE/IDLE, cleared on the next SAMPLE entry.
REQ-033 En dropped after 3 comparisons -> next cycle IDLE, Op=Om=0, trial_cnt=0, vin_ready=1.
REQ-034 rst=0 between edges during CONVERT -> Op, Om, cmp_valid, trial_cnt go 0 without a clk edge; vin_valid pulse while in CONVERT leaves vin_q unchanged.

Source files
------------

// File: rtl/sar_afe_model.sv
// sar_afe_model
// Behavioural model of the analog front end of a SAR ADC: sample-and-hold
// register plus a registered comparator.  A sample is taken in IDLE, held
// through SAMPLE, then compared against the SAR logic's DAC trial codes
// (B, with complement BN) once per cycle in CONVERT.  After eight
// comparisons the block passes through DONE back to IDLE.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   En         conversion enable (shared with the SAR algorithm block)
//   vin_data   8-bit unsigned input code to convert
//   vin_valid  vin_data offered this cycle
//   vin_ready  sample can be accepted (IDLE only)
//   B, BN      DAC trial code and its expected complement
//   Op, Om     registered comparator decision (vin_q >= B -> Op)
//   cmp_valid  Op/Om carry a decision for the previous cycle's B
//   trial_cnt  comparisons completed in the current conversion, 0..8
//   err        sticky flag: B/BN not complementary during CONVERT
module sar_afe_model (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [7:0] vin_data,
  input  logic       vin_valid,
  output logic       vin_ready,
  input  logic [7:0] B,
  input  logic [7:0] BN,
  output logic       Op,
  output logic       Om,
  output logic       cmp_valid,
  output logic [3:0] trial_cnt,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] vin_q;
  logic [7:0] vin_q_d;
  logic       op_d;
  logic       om_d;
  logic       cmp_valid_d;
  logic [3:0] trial_cnt_d;
  logic       err_d;
  logic       vin_ready_d;
  logic       accept;

  // vin_ready is registered so that it stays low during reset and for the
  // first cycle after release; a sample is only taken while it is high.
  assign accept = (state == IDLE) && vin_ready && vin_valid;

  // Next-state and next-value logic.  Every output is registered, so each
  // state describes what the outputs become after the coming edge.  The
  // eighth decision is therefore visible during the DONE cycle, and DONE
  // drives Op/Om/cmp_valid back to zero for the return to IDLE.
  always_comb begin
    next_state  = state;
    vin_q_d     = vin_q;
    op_d        = 1'b0;
    om_d        = 1'b0;
    cmp_valid_d = 1'b0;
    trial_cnt_d = trial_cnt;
    err_d       = err;
    unique case (state)
      IDLE: begin
        trial_cnt_d = 4'd0;
        if (accept) begin
          vin_q_d    = vin_data;
          err_d      = 1'b0;
          next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        trial_cnt_d = 4'd0;
        if (En) begin
          next_state = CONVERT;
        end
      end
      CONVERT: begin
        if (BN != ~B) begin
          err_d = 1'b1;
        end
        if (!En) begin
          trial_cnt_d = 4'd0;
          next_state  = IDLE;
        end else begin
          op_d        = (vin_q >= B);
          om_d        = (vin_q < B);
          cmp_valid_d = 1'b1;
          trial_cnt_d = trial_cnt + 4'd1;
          if (trial_cnt == 4'd7) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        trial_cnt_d = 4'd0;
        next_state  = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    vin_ready_d = (next_state == IDLE);
  end

  // State and output registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vin_q     <= 8'h00;
      Op        <= 1'b0;
      Om        <= 1'b0;
      cmp_valid <= 1'b0;
      trial_cnt <= 4'd0;
      err       <= 1'b0;
      vin_ready <= 1'b0;
    end else begin
      state     <= next_state;
      vin_q     <= vin_q_d;
      Op        <= op_d;
      Om        <= om_d;
      cmp_valid <= cmp_valid_d;
      trial_cnt <= trial_cnt_d;
      err       <= err_d;
      vin_ready <= vin_ready_d;
    end
  end

endmodule

// File: tb/tb_sar_afe_model.sv
// tb_sar_afe_model
// Self-checking bench for sar_afe_model.  Expected decisions come straight
// from the unsigned comparison of the held sample against each trial code;
// full SAR conversions use a binary-search trial generator and also check
// that the decisions rebuild the original sample.
module tb_sar_afe_model;

  logic       clk;
  logic       rst;
  logic       En;
  logic [7:0] vin_data;
  logic       vin_valid;
  logic       vin_ready;
  logic [7:0] B;
  logic [7:0] BN;
  logic       Op;
  logic       Om;
  logic       cmp_valid;
  logic [3:0] trial_cnt;
  logic       err;

  int         checkCount;
  int         failCount;
  logic [7:0] trialCodes [8];
  logic [7:0] lastOps;
  logic       errExp;

  sar_afe_model dut (
    .clk       (clk),
    .rst       (rst),
    .En        (En),
    .vin_data  (vin_data),
    .vin_valid (vin_valid),
    .vin_ready (vin_ready),
    .B         (B),
    .BN        (BN),
    .Op        (Op),
    .Om        (Om),
    .cmp_valid (cmp_valid),
    .trial_cnt (trial_cnt),
    .err       (err)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Binary-search trial codes an ideal SAR would issue for this sample.
  task automatic fillSarTrials(input logic [7:0] sample);
    logic [7:0] code;
    logic [7:0] trial;
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial = code | (8'h01 << b);
      trialCodes[7 - b] = trial;
      if (sample >= trial) code = trial;
    end
  endtask

  // One conversion: accept sample, optional extra SAMPLE cycle with En=0,
  // nTrials comparisons (abort by dropping En if fewer than 8), with an
  // optional non-complementary BN and an optional stray vin_valid pulse.
  task automatic applyStimulus(input logic [7:0] sample, input int nTrials,
                               input int badIdx, input bit strayValid,
                               input bit holdSample);
    logic expOp;
    checkOutput("idle_ready", vin_ready, 1);
    checkOutput("idle_cmp_valid", cmp_valid, 0);
    vin_data  = sample;
    vin_valid = 1'b1;
    En        = 1'b0;
    tick();
    vin_valid = 1'b0;
    vin_data  = ~sample;
    errExp    = 1'b0;
    checkOutput("sample_ready", vin_ready, 0);
    checkOutput("sample_err_clear", err, 0);
    checkOutput("sample_op", Op, 0);
    if (holdSample) begin
      tick();
      checkOutput("hold_ready", vin_ready, 0);
      checkOutput("hold_cnt", trial_cnt, 0);
      checkOutput("hold_cmp_valid", cmp_valid, 0);
    end
    En = 1'b1;
    tick();
    checkOutput("conv_entry_cmp_valid", cmp_valid, 0);
    checkOutput("conv_entry_cnt", trial_cnt, 0);
    for (int i = 0; i < nTrials; i++) begin
      B         = trialCodes[i];
      BN        = (i == badIdx) ? trialCodes[i] : ~trialCodes[i];
      vin_valid = strayValid && (i == 1);
      tick();
      vin_valid = 1'b0;
      if (i == badIdx) errExp = 1'b1;
      expOp = (sample >= trialCodes[i]);
      lastOps[7 - i] = Op;
      checkOutput("op", Op, expOp);
      checkOutput("om", Om, !expOp);
      checkOutput("cmp_valid", cmp_valid, 1);
      checkOutput("trial_cnt", trial_cnt, i + 1);
      checkOutput("err", err, errExp);
      checkOutput("op_om_exclusive", Op & Om, 0);
    end
    B  = 8'($urandom);
    BN = ~B;
    if (nTrials == 8) begin
      checkOutput("done_ready", vin_ready, 0);
      tick();
    end else begin
      En = 1'b0;
      tick();
    end
    En = 1'b0;
    checkOutput("end_op", Op, 0);
    checkOutput("end_om", Om, 0);
    checkOutput("end_cmp_valid", cmp_valid, 0);
    checkOutput("end_cnt", trial_cnt, 0);
    checkOutput("end_ready", vin_ready, 1);
    checkOutput("end_err", err, errExp);
  endtask

  initial begin
    logic [7:0] sample;
    logic [7:0] rebuilt;
    int         nTrials;
    int         badIdx;
    bit         sarMode;
    checkCount = 0;
    failCount  = 0;
    errExp     = 1'b0;
    lastOps    = 8'h00;
    En         = 1'b0;
    vin_data   = 8'h00;
    vin_valid  = 1'b0;
    B          = 8'h00;
    BN         = 8'hFF;
    rst        = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_ready", vin_ready, 0);
    checkOutput("rst_op", Op, 0);
    checkOutput("rst_cnt", trial_cnt, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("rst_release_ready", vin_ready, 1);

    // Reference conversion of 0xA5 with the ideal SAR trial list.
    trialCodes = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    applyStimulus(8'hA5, 8, -1, 1'b0, 1'b0);
    checkOutput("a5_op_sequence", lastOps, 8'b1010_0101);

    // Equality and off-by-one at the bottom and top of the range.
    trialCodes[0] = 8'h00;
    trialCodes[1] = 8'h01;
    applyStimulus(8'h00, 2, -1, 1'b0, 1'b1);
    trialCodes[0] = 8'hFF;
    applyStimulus(8'hFF, 1, -1, 1'b0, 1'b0);

    // Non-complementary BN: sticky through DONE/IDLE, cleared on next sample.
    fillSarTrials(8'h3C);
    applyStimulus(8'h3C, 8, 0, 1'b0, 1'b0);
    fillSarTrials(8'h5A);
    applyStimulus(8'h5A, 3, -1, 1'b1, 1'b0);

    // Randomised conversions, full SAR searches and arbitrary trial codes.
    for (int n = 0; n < 16; n++) begin
      sample  = 8'($urandom);
      sarMode = 1'($urandom_range(0, 1));
      nTrials = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(1, 7));
      badIdx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nTrials - 1)) : -1;
      if (sarMode) fillSarTrials(sample);
      else for (int i = 0; i < 8; i++) trialCodes[i] = 8'($urandom);
      applyStimulus(sample, nTrials, badIdx, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      if (sarMode && nTrials == 8) begin
        rebuilt = 8'h00;
        for (int i = 0; i < 8; i++) if (lastOps[7 - i]) rebuilt = trialCodes[i];
        checkOutput("sar_rebuilt_code", rebuilt, sample);
      end
    end

    // Reset between edges in the middle of CONVERT.
    fillSarTrials(8'h77);
    vin_data  = 8'h77;
    vin_valid = 1'b1;
    tick();
    vin_valid = 1'b0;
    En = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      B  = trialCodes[i];
      BN = ~trialCodes[i];
      tick();
    end
    checkOutput("pre_rst_cnt", trial_cnt, 3);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_op", Op, 0);
    checkOutput("mid_rst_om", Om, 0);
    checkOutput("mid_rst_cmp_valid", cmp_valid, 0);
    checkOutput("mid_rst_cnt", trial_cnt, 0);
    checkOutput("mid_rst_ready", vin_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_ready", vin_ready, 1);
    tick();
    checkOutput("post_rst_cmp_valid", cmp_valid, 0);
    checkOutput("post_rst_op", Op, 0);
    checkOutput("post_rst_cnt", trial_cnt, 0);
    En = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
